// File: rtl/booth_seq_divider.sv
// booth_seq_divider: sequential signed restoring divider.
// Takes a 2N-bit signed dividend and an N-bit signed divisor. It produces a
// 2N-bit quotient truncated toward zero and an N-bit remainder that carries
// the dividend's sign. One accepted operation takes 2N CALC cycles plus one
// FIX cycle.
// Optional build macro: DIVIDER_DBZ_DETECT_EN. When it is defined, a zero
// divisor sets dbz=1 and returns quotient=-1, remainder=0. When it is not
// defined, dbz is tied to 0.
module booth_seq_divider #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             ready,
    output logic             done,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             dbz
);

    localparam int W  = 2 * N;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state;
    logic [W-1:0]    acc_q;      // dividend magnitude, shifted out MSB-first; quotient bits shift in
    logic [N:0]      div_mag;    // |divisor|, one extra bit so -2^(N-1) is representable
    logic [N-1:0]    rem_q;      // partial remainder, always < |divisor| <= 2^(N-1)
    logic [CW-1:0]   count;
    logic            q_neg;
    logic            r_neg;

    logic [W-1:0]    dvd_mag;
    logic [N:0]      dvs_ext;
    logic [N:0]      dvs_mag;
    logic [N:0]      rem_sh;
    logic [N-1:0]    trial;
    logic            fits;

    // Operand magnitudes and one restoring step of the datapath
    always_comb begin
        dvd_mag = dividend[W-1] ? -dividend : dividend;
        dvs_ext = {divisor[N-1], divisor};
        dvs_mag = dvs_ext[N] ? -dvs_ext : dvs_ext;
        rem_sh  = {rem_q, acc_q[W-1]};
        fits    = (rem_sh >= div_mag);
        trial   = rem_sh[N-1:0] - div_mag[N-1:0];
    end

`ifdef DIVIDER_DBZ_DETECT_EN
    logic dbz_pend;

    // Control FSM, iteration datapath and registered outputs (zero-divisor detect build)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            dbz_pend  <= 1'b0;
            acc_q     <= '0;
            div_mag   <= '0;
            rem_q     <= '0;
            count     <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_q    <= dvd_mag;
                        div_mag  <= dvs_mag;
                        rem_q    <= '0;
                        q_neg    <= dividend[W-1] ^ divisor[N-1];
                        r_neg    <= dividend[W-1];
                        dbz      <= 1'b0;
                        ready    <= 1'b0;
                        state    <= CALC;
                        // A zero divisor skips the iteration. It spends one CALC
                        // cycle so that done lands two edges after the accept.
                        if (divisor == '0) begin
                            dbz_pend <= 1'b1;
                            count    <= CW'(W - 1);
                        end else begin
                            dbz_pend <= 1'b0;
                            count    <= '0;
                        end
                    end
                end
                CALC: begin
                    acc_q <= {acc_q[W-2:0], fits};
                    rem_q <= fits ? trial : rem_sh[N-1:0];
                    count <= count + 1'b1;
                    if (count == CW'(W - 1))
                        state <= FIX;
                end
                FIX: begin
                    if (dbz_pend) begin
                        quotient  <= '1;
                        remainder <= '0;
                        dbz       <= 1'b1;
                    end else begin
                        quotient  <= q_neg ? -acc_q : acc_q;
                        remainder <= r_neg ? -rem_q : rem_q;
                    end
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign dbz = 1'b0;

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            acc_q     <= '0;
            div_mag   <= '0;
            rem_q     <= '0;
            count     <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_q   <= dvd_mag;
                        div_mag <= dvs_mag;
                        rem_q   <= '0;
                        count   <= '0;
                        q_neg   <= dividend[W-1] ^ divisor[N-1];
                        r_neg   <= dividend[W-1];
                        ready   <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= {acc_q[W-2:0], fits};
                    rem_q <= fits ? trial : rem_sh[N-1:0];
                    count <= count + 1'b1;
                    if (count == CW'(W - 1))
                        state <= FIX;
                end
                FIX: begin
                    quotient  <= q_neg ? -acc_q : acc_q;
                    remainder <= r_neg ? -rem_q : rem_q;
                    done      <= 1'b1;
                    ready     <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_booth_seq_divider.sv
// Scoreboard bench for booth_seq_divider (N=4). The driver pushes expected results
// at issue time. A forked monitor pops and compares each result on a done pulse.
module tb_booth_seq_divider;

    localparam int N   = 4;
    localparam int W   = 2 * N;
    localparam int LAT = 2 * N + 2;   // negedge-count from issue to the done cycle

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   dividend;
    logic [N-1:0]   divisor;
    logic           ready;
    logic           done;
    logic [W-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           dbz;

    booth_seq_divider #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string name;
        int    q;
        int    r;
        bit    dz;
        bit    chk_qr;
        int    due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending result", cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_done_cycle"}, cyc, e.due);
                    chk({e.name, "_ready"}, int'(ready), 1);
                    chk({e.name, "_dbz"}, int'(dbz), int'(e.dz));
                    if (e.chk_qr) begin
                        chk({e.name, "_quotient"}, int'($signed(quotient)), e.q);
                        chk({e.name, "_remainder"}, int'($signed(remainder)), e.r);
                    end
                end
            end
        end
    endtask

    task automatic issue(input string nm, input int dvd, input int dvs, input int q,
                         input int r, input bit dz, input bit cq, input int lat);
        exp_t e;
        start    = 1'b1;
        dividend = W'(dvd);
        divisor  = N'(dvs);
        e.name   = nm;
        e.q      = q;
        e.r      = r;
        e.dz     = dz;
        e.chk_qr = cq;
        e.due    = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d results pending, expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_op(input string nm, input int dvd, input int dvs, input int q, input int r);
        issue(nm, dvd, dvs, q, r, 1'b0, 1'b1, LAT);
        @(negedge clk);
        start = 1'b0;
        drain(nm);
    endtask

    // Directed sign and extreme vectors with hand-computed results
    string tv_n[7] = '{"m6_2", "m36_m6", "7_m2", "m7_2", "m128_m8", "127_m8", "m128_m1"};
    int    tv_a[7] = '{-6, -36,  7, -7, -128, 127, -128};
    int    tv_b[7] = '{ 2,  -6, -2,  2,   -8,  -8,   -1};
    int    tv_q[7] = '{-3,   6, -3, -3,   16, -15, -128};
    int    tv_r[7] = '{ 0,   0,  1, -1,    0,   7,    0};

    initial begin
        fork
            monitor();
        join_none

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready", int'(ready), 1);
        chk("reset_done", int'(done), 0);
        chk("reset_quotient", int'(quotient), 0);
        chk("reset_remainder", int'(remainder), 0);
        chk("reset_dbz", int'(dbz), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 15/5, with ready held low through the whole iteration
        issue("d15_5", 15, 5, 3, 0, 1'b0, 1'b1, LAT);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2 * N + 1; i++) begin
            chk("calc_ready_low", int'(ready), 0);
            @(negedge clk);
        end
        drain("d15_5");

        for (int t = 0; t < 7; t++)
            do_op(tv_n[t], tv_a[t], tv_b[t], tv_q[t], tv_r[t]);

        // Start pulses with other operands while busy must be ignored
        issue("ignore_50_7", 50, 7, 7, 1, 1'b0, 1'b1, LAT);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start    = (i == 1 || i == 2 || i == 4);
            dividend = 8'd1;
            divisor  = 4'd1;
        end
        start = 1'b0;
        drain("ignore_50_7");

        // Back-to-back: start stays high and the next pair is accepted in the done cycle
        issue("b2b_100_3", 100, 3, 33, 1, 1'b0, 1'b1, LAT);
        @(negedge clk);
        dividend = 8'd1;
        divisor  = 4'd1;
        for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
        chk("b2b_ready_return", int'(ready), 1);
        issue("b2b_1_1", 1, 1, 1, 0, 1'b0, 1'b1, LAT);
        @(negedge clk);
        start = 1'b0;
        drain("b2b");

        // Reset in the middle of CALC aborts with no done pulse
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", int'(ready), 1);
        chk("midrst_done", int'(done), 0);
        chk("midrst_quotient", int'(quotient), 0);
        chk("midrst_remainder", int'(remainder), 0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_no_done", int'(done), 0);
        do_op("after_rst_9_4", 9, 4, 2, 1);

        // Zero divisor
`ifdef DIVIDER_DBZ_DETECT_EN
        issue("dbz_50_0", 50, 0, -1, 0, 1'b1, 1'b1, 3);
`else
        issue("dbz_50_0", 50, 0, 0, 0, 1'b0, 1'b0, LAT);
`endif
        @(negedge clk);
        start = 1'b0;
        drain("dbz_50_0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000, expected earlier finish");
        $fatal(1);
    end

endmodule
